cordic_sincos_iter_core: RTL

Iterative CORDIC rotation engine that sits directly downstream of the sin/cos preprocessing stage. It consumes that stage's initial vector (cos = K, sin = 0), its range-corrected angle and its sign flag. It performs one micro-rotation per cycle for STAGES cycles and presents sign-corrected sin/cos to the downstream consumer through a valid/ready handshake. It trades throughput for area against the unrolled stage pipeline: one sample in flight at a time.

---
 rtl/cordic_sincos_iter_core_pkg.sv | 28 ++
 rtl/cordic_sincos_iter_core_microrot.sv | 28 ++
 rtl/cordic_sincos_iter_core.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cordic_sincos_iter_core_pkg.sv
// Shared CORDIC sin/cos constants: atan table in Q2.30, stage limit and iterative engine states.
package pkg_cordic_sincos;

  localparam int MAX_STAGES  = 24;
  localparam int MAX_D_WIDTH = 32;
  localparam int ITER_W      = $clog2(MAX_STAGES);

  // atan(2^-i) in Q2.30; narrowed to the datapath width by round-half-up, as K is
  localparam logic [MAX_D_WIDTH-1:0] ATAN [MAX_STAGES] = '{
    32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
    32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
    32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
    32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
    32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
    32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F
  };

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} cordic_iter_state_t;

  function automatic logic [MAX_D_WIDTH-1:0] atan_rnd(input logic [ITER_W-1:0] idx,
                                                      input int bits);
    logic [MAX_D_WIDTH-1:0] v;
    if (int'(idx) >= MAX_STAGES) return '0;
    v = ATAN[idx] + (MAX_D_WIDTH'(1) << (MAX_D_WIDTH - bits - 1));
    return v >> (MAX_D_WIDTH - bits);
  endfunction

endpackage

// File: rtl/cordic_sincos_iter_core_microrot.sv
// One combinational CORDIC rotation-mode step; direction follows the sign of the residual angle.
module cordic_sincos_microrot
  import pkg_cordic_sincos::*;
#(
  parameter int BITS = 16
) (
  input  logic signed [BITS-1:0] x_i,
  input  logic signed [BITS-1:0] y_i,
  input  logic signed [BITS-1:0] z_i,
  input  logic [ITER_W-1:0]      shift_i,
  input  logic signed [BITS-1:0] atan_i,
  output logic signed [BITS-1:0] x_o,
  output logic signed [BITS-1:0] y_o,
  output logic signed [BITS-1:0] z_o
);

  logic signed [BITS-1:0] xs, ys;
  logic                   pos;

  assign xs  = x_i >>> shift_i;
  assign ys  = y_i >>> shift_i;
  assign pos = ~z_i[BITS-1];

  assign x_o = pos ? x_i - ys     : x_i + ys;
  assign y_o = pos ? y_i + xs     : y_i - xs;
  assign z_o = pos ? z_i - atan_i : z_i + atan_i;

endmodule

// File: rtl/cordic_sincos_iter_core.sv
// Iterative CORDIC sin/cos engine: one micro-rotation per enabled cycle, one sample in flight.
// Build option CORDIC_SINCOS_ITER_DROP_CNT_EN adds a saturating count of refused samples.
module cordic_sincos_iter_core
  import pkg_cordic_sincos::*;
#(
  parameter int STAGES = 16,
  parameter int BITS   = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_valid,
  input  logic            i_sign,
  input  logic [BITS-1:0] i_cos,
  input  logic [BITS-1:0] i_sin,
  input  logic [BITS-1:0] i_theta,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_cos,
  output logic [BITS-1:0] o_sin
`ifdef CORDIC_SINCOS_ITER_DROP_CNT_EN
  ,
  output logic [15:0]     o_drop_cnt
`endif
);

  if (STAGES < 2 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("STAGES out of range");
  end

  localparam logic signed [BITS-1:0] SMIN = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [BITS-1:0] SMAX = {1'b0, {(BITS-1){1'b1}}};

  function automatic logic signed [BITS-1:0] neg_sat(input logic signed [BITS-1:0] v);
    if (v == SMIN) return SMAX;
    return -v;
  endfunction

  cordic_iter_state_t     state_q;
  logic [ITER_W-1:0]      iter_q;
  logic signed [BITS-1:0] x_q, y_q, z_q;
  logic                   sign_q;
  logic                   valid_q;
  logic [BITS-1:0]        cos_q, sin_q;

  logic signed [BITS-1:0] x_d, y_d, z_d, atan_cur;
  logic                   accept, last;

  assign o_ready  = (state_q == IDLE) || ((state_q == DONE) && i_ready);
  assign accept   = i_en && i_valid && o_ready;
  assign last     = (iter_q == ITER_W'(STAGES - 1));
  assign atan_cur = BITS'(atan_rnd(iter_q, BITS));

  cordic_sincos_microrot #(.BITS(BITS)) u_rot (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .shift_i(iter_q),
    .atan_i (atan_cur),
    .x_o    (x_d),
    .y_o    (y_d),
    .z_o    (z_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else if (i_en) begin
      unique case (state_q)
        ROTATE: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + ITER_W'(1);
          if (last) begin
            cos_q   <= sign_q ? neg_sat(x_d) : x_d;
            sin_q   <= sign_q ? neg_sat(y_d) : y_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
      // accept is only possible in IDLE or a draining DONE, so it overrides the branch above
      if (accept) begin
        x_q     <= i_cos;
        y_q     <= i_sin;
        z_q     <= i_theta;
        sign_q  <= i_sign;
        iter_q  <= '0;
        state_q <= ROTATE;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_cos   = cos_q;
  assign o_sin   = sin_q;

`ifdef CORDIC_SINCOS_ITER_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (i_en && i_valid && !o_ready && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) drop_q <= '0;
    else          drop_q <= drop_d;
  end

  assign o_drop_cnt = drop_q;
`endif

endmodule
